// File: rtl/urv_rf_wport_sched_pkg.sv
// -----------------------------------------------------------------------------
// urv_rf_wport_sched_pkg
// Shared definitions for the register-file write-port scheduler:
//   - XLEN / register index width / register count
//   - requester encoding used by the write-port arbiter (grant_e)
//   - small helper to recognise the hard-wired zero register
// No ports (package).
// -----------------------------------------------------------------------------
package urv_rf_wport_sched_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int NREGS = 32;

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_PIPE  = 2'd1,
    GRANT_MULTI = 2'd2,
    GRANT_DBG   = 2'd3
  } grant_e;

  // x0 is never written and never tracked.
  function automatic logic is_x0(input logic [REG_W-1:0] idx);
    return (idx == {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/urv_rf_scoreboard.sv
// -----------------------------------------------------------------------------
// urv_rf_scoreboard
// Pending-result mask for x1..x31 plus the decode hazard lookup.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   set_i, set_rd_i     multi-cycle issue: mark destination pending
//   clr_i, clr_rd_i     multi-cycle transfer: clear destination
//   rs1_i, rs2_i, rd_i  decode-stage operand indices
//   hazard_o            any decode operand is pending (combinational)
// -----------------------------------------------------------------------------
module urv_rf_scoreboard
  import urv_rf_wport_sched_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [REG_W-1:0] set_rd_i,
  input  logic             clr_i,
  input  logic [REG_W-1:0] clr_rd_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [REG_W-1:0] rd_i,
  output logic             hazard_o
);

  logic [NREGS-1:1] pending_r;
  logic [NREGS-1:1] pending_nxt_s;
  logic [NREGS-1:0] set_vec_s;
  logic [NREGS-1:0] clr_vec_s;
  logic [NREGS-1:0] pending_full_s;

  // One-hot set/clear vectors; clear is applied before set so set wins.
  always_comb begin
    set_vec_s     = {NREGS{1'b0}};
    clr_vec_s     = {NREGS{1'b0}};
    if (set_i && !is_x0(set_rd_i)) begin
      set_vec_s[set_rd_i] = 1'b1;
    end else begin
      set_vec_s = {NREGS{1'b0}};
    end
    if (clr_i && !is_x0(clr_rd_i)) begin
      clr_vec_s[clr_rd_i] = 1'b1;
    end else begin
      clr_vec_s = {NREGS{1'b0}};
    end
    pending_nxt_s = (pending_r & ~clr_vec_s[NREGS-1:1]) | set_vec_s[NREGS-1:1];
  end

  // Pending mask register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_r <= {(NREGS-1){1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Bit 0 is a constant zero so index 0 never reports a hazard.
  assign pending_full_s = {pending_r, 1'b0};
  assign hazard_o = pending_full_s[rs1_i] | pending_full_s[rs2_i] | pending_full_s[rd_i];

endmodule

// File: rtl/urv_rf_wport_sched.sv
// -----------------------------------------------------------------------------
// urv_rf_wport_sched
// Shares the single register-file write port between pipeline writeback
// (highest priority, never refused), the multi-cycle unit and the debug port
// (lowest priority). Tracks outstanding multi-cycle destinations and stalls
// decode on hazards; freezes the pipeline when a multi-cycle result has been
// refused STARVE_MAX cycles in a row.
// Optional feature: `define URV_RF_DEBUG_PORT_EN enables debug arbitration;
// without it the dbg_* inputs are ignored and dbg_ack_o is tied low.
// Ports:
//   clk_i, rst_i                         clock, async active-low reset
//   w_we_i, w_rd_i, w_value_i            pipeline writeback request
//   m_issue_i, m_issue_rd_i              multi-cycle issue (scoreboard set)
//   m_valid_i, m_rd_i, m_value_i         multi-cycle result
//   m_ready_o                            multi-cycle result accepted
//   dbg_req_i, dbg_rd_i, dbg_value_i     debug write request (held to ack)
//   dbg_ack_o                            one-cycle debug acknowledge
//   d_rs1_i, d_rs2_i, d_rd_i, d_stall_o  decode hazard lookup / stall
//   hold_pipe_o                          freeze pipeline writeback
//   rf_rd_o, rf_value_o, rf_store_o      register-file write port
// -----------------------------------------------------------------------------
module urv_rf_wport_sched
  import urv_rf_wport_sched_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             w_we_i,
  input  logic [REG_W-1:0] w_rd_i,
  input  logic [XLEN-1:0]  w_value_i,
  input  logic             m_issue_i,
  input  logic [REG_W-1:0] m_issue_rd_i,
  input  logic             m_valid_i,
  input  logic [REG_W-1:0] m_rd_i,
  input  logic [XLEN-1:0]  m_value_i,
  output logic             m_ready_o,
  input  logic             dbg_req_i,
  input  logic [REG_W-1:0] dbg_rd_i,
  input  logic [XLEN-1:0]  dbg_value_i,
  output logic             dbg_ack_o,
  input  logic [REG_W-1:0] d_rs1_i,
  input  logic [REG_W-1:0] d_rs2_i,
  input  logic [REG_W-1:0] d_rd_i,
  output logic             d_stall_o,
  output logic             hold_pipe_o,
  output logic [REG_W-1:0] rf_rd_o,
  output logic [XLEN-1:0]  rf_value_o,
  output logic             rf_store_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  grant_e           grant_s;
  logic             m_xfer_s;
  logic             m_refused_s;
  logic             dbg_gnt_s;
  logic [REG_W-1:0] win_rd_s;
  logic [XLEN-1:0]  win_value_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             hold_r;
  logic             hold_nxt_s;
  logic             hazard_s;

  assign m_ready_o   = m_valid_i & ~w_we_i;
  assign m_xfer_s    = m_valid_i & m_ready_o;
  assign m_refused_s = m_valid_i & w_we_i;

`ifdef URV_RF_DEBUG_PORT_EN
  logic dbg_ack_r;

  // The ack cycle blocks a re-grant while the requester is still dropping req.
  assign dbg_gnt_s = dbg_req_i & ~w_we_i & ~m_valid_i & ~dbg_ack_r;

  // Debug acknowledge, one cycle after the grant cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dbg_ack_r <= 1'b0;
    end else begin
      dbg_ack_r <= dbg_gnt_s;
    end
  end

  assign dbg_ack_o = dbg_ack_r;
`else
  logic unused_dbg_req_s;

  assign unused_dbg_req_s = dbg_req_i;
  assign dbg_gnt_s        = 1'b0;
  assign dbg_ack_o        = 1'b0;
`endif

  // Fixed-priority arbitration: pipeline, then multi-cycle, then debug.
  always_comb begin
    grant_s = GRANT_NONE;
    if (w_we_i) begin
      grant_s = GRANT_PIPE;
    end else if (m_valid_i) begin
      grant_s = GRANT_MULTI;
    end else if (dbg_gnt_s) begin
      grant_s = GRANT_DBG;
    end else begin
      grant_s = GRANT_NONE;
    end
  end

  // Write-port data mux for the winning requester.
  always_comb begin
    win_rd_s    = {REG_W{1'b0}};
    win_value_s = {XLEN{1'b0}};
    case (grant_s)
      GRANT_PIPE: begin
        win_rd_s    = w_rd_i;
        win_value_s = w_value_i;
      end
      GRANT_MULTI: begin
        win_rd_s    = m_rd_i;
        win_value_s = m_value_i;
      end
      GRANT_DBG: begin
        win_rd_s    = dbg_rd_i;
        win_value_s = dbg_value_i;
      end
      default: begin
        win_rd_s    = {REG_W{1'b0}};
        win_value_s = {XLEN{1'b0}};
      end
    endcase
  end

  // A winner targeting x0 is consumed but produces no store.
  assign rf_rd_o    = win_rd_s;
  assign rf_value_o = win_value_s;
  assign rf_store_o = (grant_s != GRANT_NONE) & ~is_x0(win_rd_s);

  // Starvation counter and hold: hold rises on the edge the counter reaches
  // STARVE_MAX and stays until a multi-cycle result actually transfers.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    hold_nxt_s = hold_r;
    if (m_refused_s) begin
      cnt_nxt_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
    end else begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end
    if (m_xfer_s) begin
      hold_nxt_s = 1'b0;
    end else if (cnt_nxt_s == CNT_MAX) begin
      hold_nxt_s = 1'b1;
    end else begin
      hold_nxt_s = hold_r;
    end
  end

  // Starvation state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r  <= {CNT_W{1'b0}};
      hold_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      hold_r <= hold_nxt_s;
    end
  end

  assign hold_pipe_o = hold_r;

  urv_rf_scoreboard u_scoreboard (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_i    (m_issue_i),
    .set_rd_i (m_issue_rd_i),
    .clr_i    (m_xfer_s),
    .clr_rd_i (m_rd_i),
    .rs1_i    (d_rs1_i),
    .rs2_i    (d_rs2_i),
    .rd_i     (d_rd_i),
    .hazard_o (hazard_s)
  );

  assign d_stall_o = hazard_s | hold_r;

endmodule

// File: tb/tb_urv_rf_wport_sched.sv
// -----------------------------------------------------------------------------
// tb_urv_rf_wport_sched
// Self-checking bench: every expected register-file write is queued when the
// stimulus is driven and popped by a negedge monitor when rf_store_o fires.
// Control outputs (ready, ack, stall, hold) are checked directly.
// -----------------------------------------------------------------------------
module tb_urv_rf_wport_sched;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        w_we_i;
  logic [4:0]  w_rd_i;
  logic [31:0] w_value_i;
  logic        m_issue_i;
  logic [4:0]  m_issue_rd_i;
  logic        m_valid_i;
  logic [4:0]  m_rd_i;
  logic [31:0] m_value_i;
  logic        m_ready_o;
  logic        dbg_req_i;
  logic [4:0]  dbg_rd_i;
  logic [31:0] dbg_value_i;
  logic        dbg_ack_o;
  logic [4:0]  d_rs1_i;
  logic [4:0]  d_rs2_i;
  logic [4:0]  d_rd_i;
  logic        d_stall_o;
  logic        hold_pipe_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_value_o;
  logic        rf_store_o;

  int  tests_run    = 0;
  int  tests_failed = 0;
  wr_t exp_q[$];

  urv_rf_wport_sched #(.STARVE_MAX(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .w_we_i       (w_we_i),
    .w_rd_i       (w_rd_i),
    .w_value_i    (w_value_i),
    .m_issue_i    (m_issue_i),
    .m_issue_rd_i (m_issue_rd_i),
    .m_valid_i    (m_valid_i),
    .m_rd_i       (m_rd_i),
    .m_value_i    (m_value_i),
    .m_ready_o    (m_ready_o),
    .dbg_req_i    (dbg_req_i),
    .dbg_rd_i     (dbg_rd_i),
    .dbg_value_i  (dbg_value_i),
    .dbg_ack_o    (dbg_ack_o),
    .d_rs1_i      (d_rs1_i),
    .d_rs2_i      (d_rs2_i),
    .d_rd_i       (d_rd_i),
    .d_stall_o    (d_stall_o),
    .hold_pipe_o  (hold_pipe_o),
    .rf_rd_o      (rf_rd_o),
    .rf_value_o   (rf_value_o),
    .rf_store_o   (rf_store_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] val);
    wr_t e;
    e.rd  = rd;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    w_we_i = 1'b0; w_rd_i = 5'd0; w_value_i = 32'd0;
    m_issue_i = 1'b0; m_issue_rd_i = 5'd0;
    m_valid_i = 1'b0; m_rd_i = 5'd0; m_value_i = 32'd0;
    dbg_req_i = 1'b0; dbg_rd_i = 5'd0; dbg_value_i = 32'd0;
    d_rs1_i = 5'd0; d_rs2_i = 5'd0; d_rd_i = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  // Write monitor: each store must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (rf_store_o) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {27'd0, rf_rd_o}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_rd", {27'd0, rf_rd_o}, {27'd0, e.rd});
        chk("wr_value", rf_value_o, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    idle();
    repeat (2) tick();
    settle();
    chk("rst_store", 32'(rf_store_o), 32'd0);
    chk("rst_hold", 32'(hold_pipe_o), 32'd0);
    chk("rst_ack", 32'(dbg_ack_o), 32'd0);
    chk("rst_stall", 32'(d_stall_o), 32'd0);
    chk("rst_ready", 32'(m_ready_o), 32'd0);
    tick();
    rst_i = 1'b1;

    // Pipeline beats multi-cycle; multi-cycle goes next cycle.
    w_we_i = 1'b1; w_rd_i = 5'd5; w_value_i = 32'h0000_1234;
    m_valid_i = 1'b1; m_rd_i = 5'd6; m_value_i = 32'h0000_600D;
    push(5'd5, 32'h0000_1234);
    settle();
    chk("t1_rf_rd_pipe", 32'(rf_rd_o), 32'd5);
    chk("t1_ready_refused", 32'(m_ready_o), 32'd0);
    tick();
    w_we_i = 1'b0;
    push(5'd6, 32'h0000_600D);
    settle();
    chk("t1_rf_rd_multi", 32'(rf_rd_o), 32'd6);
    chk("t1_ready_taken", 32'(m_ready_o), 32'd1);
    tick();
    idle();

    // RAW hazard on rd=7 appears after issue, clears after transfer.
    m_issue_i = 1'b1; m_issue_rd_i = 5'd7; d_rs2_i = 5'd7;
    settle();
    chk("t2_issue_cycle", 32'(d_stall_o), 32'd0);
    tick();
    m_issue_i = 1'b0;
    settle();
    chk("t2_raw_stall", 32'(d_stall_o), 32'd1);
    tick();
    d_rs2_i = 5'd8;
    settle();
    chk("t2_other_reg", 32'(d_stall_o), 32'd0);
    tick();
    d_rs2_i = 5'd7;
    m_valid_i = 1'b1; m_rd_i = 5'd7; m_value_i = 32'h0000_0077;
    push(5'd7, 32'h0000_0077);
    settle();
    chk("t2_xfer_cycle", 32'(d_stall_o), 32'd1);
    tick();
    m_valid_i = 1'b0;
    settle();
    chk("t2_cleared", 32'(d_stall_o), 32'd0);
    tick();
    idle();

    // WAW on rd=12; a rd=0 result is consumed without write or mask change.
    m_issue_i = 1'b1; m_issue_rd_i = 5'd12;
    tick();
    m_issue_i = 1'b0; d_rd_i = 5'd12;
    settle();
    chk("t3_waw_stall", 32'(d_stall_o), 32'd1);
    tick();
    m_valid_i = 1'b1; m_rd_i = 5'd0; m_value_i = 32'h0000_BAD0;
    settle();
    chk("t3_rd0_ready", 32'(m_ready_o), 32'd1);
    chk("t3_rd0_store", 32'(rf_store_o), 32'd0);
    tick();
    m_valid_i = 1'b0;
    settle();
    chk("t3_mask_kept", 32'(d_stall_o), 32'd1);
    tick();
    m_valid_i = 1'b1; m_rd_i = 5'd12; m_value_i = 32'h0000_000C;
    push(5'd12, 32'h0000_000C);
    tick();
    m_valid_i = 1'b0;
    settle();
    chk("t3_cleared", 32'(d_stall_o), 32'd0);
    tick();
    idle();

    // Starvation: four refused cycles raise hold; transfer releases it.
    m_valid_i = 1'b1; m_rd_i = 5'd9; m_value_i = 32'h0000_9999;
    for (int i = 0; i < 4; i++) begin
      w_we_i = 1'b1; w_rd_i = 5'(10 + i); w_value_i = 32'h0000_0100 + 32'(i);
      push(5'(10 + i), 32'h0000_0100 + 32'(i));
      settle();
      chk("t4_hold_before", 32'(hold_pipe_o), 32'd0);
      chk("t4_refused", 32'(m_ready_o), 32'd0);
      tick();
    end
    w_we_i = 1'b0;
    push(5'd9, 32'h0000_9999);
    settle();
    chk("t4_hold_on", 32'(hold_pipe_o), 32'd1);
    chk("t4_hold_stall", 32'(d_stall_o), 32'd1);
    chk("t4_xfer_ready", 32'(m_ready_o), 32'd1);
    tick();
    m_valid_i = 1'b0;
    settle();
    chk("t4_hold_off", 32'(hold_pipe_o), 32'd0);
    chk("t4_stall_off", 32'(d_stall_o), 32'd0);
    tick();
    idle();

    // Debug write on an idle port.
    dbg_req_i = 1'b1; dbg_rd_i = 5'd3; dbg_value_i = 32'hDEAD_BEEF;
`ifdef URV_RF_DEBUG_PORT_EN
    push(5'd3, 32'hDEAD_BEEF);
    settle();
    chk("t5_dbg_store", 32'(rf_store_o), 32'd1);
    chk("t5_ack_grant_cyc", 32'(dbg_ack_o), 32'd0);
    tick();
    settle();
    chk("t5_ack", 32'(dbg_ack_o), 32'd1);
    chk("t5_no_regrant", 32'(rf_store_o), 32'd0);
    tick();
    dbg_req_i = 1'b0;
    settle();
    chk("t5_ack_once", 32'(dbg_ack_o), 32'd0);
`else
    settle();
    chk("t5_dbg_no_store", 32'(rf_store_o), 32'd0);
    tick();
    settle();
    chk("t5_no_ack", 32'(dbg_ack_o), 32'd0);
    chk("t5_no_store2", 32'(rf_store_o), 32'd0);
    tick();
    dbg_req_i = 1'b0;
    settle();
    chk("t5_no_ack2", 32'(dbg_ack_o), 32'd0);
`endif
    tick();
    idle();

    // Asynchronous reset with x3 and x9 pending; late result still written.
    m_issue_i = 1'b1; m_issue_rd_i = 5'd3;
    tick();
    m_issue_rd_i = 5'd9;
    tick();
    m_issue_i = 1'b0; d_rs1_i = 5'd3; d_rs2_i = 5'd9;
    settle();
    chk("t6_pending", 32'(d_stall_o), 32'd1);
    #1;
    rst_i = 1'b0;
    #1;
    chk("t6_in_reset", 32'(d_stall_o), 32'd0);
    tick();
    rst_i = 1'b1;
    settle();
    chk("t6_after_reset", 32'(d_stall_o), 32'd0);
    tick();
    m_valid_i = 1'b1; m_rd_i = 5'd9; m_value_i = 32'h0000_0099;
    push(5'd9, 32'h0000_0099);
    settle();
    chk("t6_late_ready", 32'(m_ready_o), 32'd1);
    tick();
    m_valid_i = 1'b0;
    settle();
    chk("t6_late_stall", 32'(d_stall_o), 32'd0);
    tick();
    idle();
    settle();
    chk("q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
